// File: rtl/float_pkg.sv
// Shared encodings, constants and field helpers for the float arithmetic unit.
package float_pkg;

   typedef enum logic [1:0] {
      OP_ADD      = 2'd0,
      OP_SUB      = 2'd1,
      OP_FROM_INT = 2'd2,
      OP_CMP      = 2'd3
   } fpOp_t;

   typedef enum logic [1:0] {
      CMP_EQ    = 2'b00,
      CMP_GT    = 2'b01,
      CMP_LT    = 2'b10,
      CMP_UNORD = 2'b11
   } fpCmp_t;

   localparam int          EXP_W    = 8;
   localparam int          FRAC_W   = 23;
   localparam int          EXP_BIAS = 127;
   localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
   localparam logic [31:0] FP_PINF  = 32'h7F80_0000;

   // Exponent of an int32 magnitude whose MSB sits at bit 31 (2^31 before normalisation).
   localparam logic signed [9:0] INT_EXP_BASE = 10'sd158;

   function automatic logic isNan(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != '0);
   endfunction

   function automatic logic isInf(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] == '0);
   endfunction

endpackage

// File: rtl/fp_normalize.sv
// Leading-zero count, left shift to put the MSB at bit 31, exponent adjust.
module fp_normalize
   import float_pkg::*;
(
   input  logic [31:0]        mag,
   input  logic signed [9:0]  expIn,
   output logic [31:0]        magNorm,
   output logic signed [9:0]  expOut,
   output logic               isZero
);

   logic [5:0] lzc;

   // Highest set bit wins because later iterations overwrite earlier ones.
   always_comb begin
      lzc = 6'd32;
      for (int i = 0; i < 32; i++)
         if (mag[i]) lzc = 6'(31 - i);
   end

   assign magNorm = mag << lzc;
   assign expOut  = expIn - $signed({4'b0, lzc});
   assign isZero  = (mag == '0);

endmodule

// File: rtl/float_arith_unit.sv
// Single-precision add/sub, int-to-float and compare with one registered result port.
module float_arith_unit
   import float_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic [1:0]  cmp,
   output logic        valid,
   output logic [31:0] debug
);

   fpOp_t opSel;
   assign opSel = fpOp_t'(op);

   // Operand decode; exponent zero (denormal) is treated as a true zero.
   logic [7:0]  eA, eB;
   logic [23:0] mA, mB;
   logic        sBEff;
   assign eA    = a[30:23];
   assign eB    = b[30:23];
   assign mA    = (eA != '0) ? {1'b1, a[22:0]} : 24'd0;
   assign mB    = (eB != '0) ? {1'b1, b[22:0]} : 24'd0;
   assign sBEff = b[31] ^ (opSel == OP_SUB);

   logic        aBig, sBig, sSmall;
   logic [7:0]  eBig, eSmall, shAmt;
   logic [23:0] mBig, mSmall;
   assign aBig   = (eA > eB) || ((eA == eB) && (mA >= mB));
   assign eBig   = aBig ? eA : eB;
   assign eSmall = aBig ? eB : eA;
   assign mBig   = aBig ? mA : mB;
   assign mSmall = aBig ? mB : mA;
   assign sBig   = aBig ? a[31] : sBEff;
   assign sSmall = aBig ? sBEff : a[31];
   assign shAmt  = eBig - eSmall;

   // Align the smaller operand with guard/round bits plus a sticky LSB, then add/sub.
   logic [26:0] extSmall, shifted, aligned;
   logic        lost;
   logic [27:0] sum;
   always_comb begin
      extSmall = {mSmall, 3'b000};
      if (shAmt >= 8'd27) begin
         shifted = '0;
         lost    = |extSmall;
      end else begin
         shifted = extSmall >> shAmt;
         lost    = ((shifted << shAmt) != extSmall);
      end
      aligned = {shifted[26:1], shifted[0] | lost};
      if (sBig == sSmall) sum = {1'b0, mBig, 3'b000} + {1'b0, aligned};
      else                sum = {1'b0, mBig, 3'b000} - {1'b0, aligned};
   end

   logic [31:0] intAbs;
   assign intAbs = a[31] ? (~a + 32'd1) : a;

   // One normaliser serves both paths: sum's hidden bit sits at bit 30, carry at bit 31.
   logic [31:0]       normIn, normMag;
   logic signed [9:0] normExpIn, normExp;
   logic              normZero;
   assign normIn    = (opSel == OP_FROM_INT) ? intAbs : {sum, 4'b0000};
   assign normExpIn = (opSel == OP_FROM_INT) ? INT_EXP_BASE : $signed({2'b00, eBig}) + 10'sd1;

   fp_normalize uNorm (
      .mag     (normIn),
      .expIn   (normExpIn),
      .magNorm (normMag),
      .expOut  (normExp),
      .isZero  (normZero)
   );

   // Result selection: specials first, then zero/underflow/overflow, then truncated value.
   logic [31:0] calcRes;
   always_comb begin
      calcRes = '0;
      if (opSel == OP_FROM_INT) begin
         if (!normZero) calcRes = {a[31], normExp[7:0], normMag[30:8]};
      end else if (isNan(a) || isNan(b) || (isInf(a) && isInf(b) && (a[31] != sBEff))) begin
         calcRes = FP_QNAN;
      end else if (isInf(a)) begin
         calcRes = a;
      end else if (isInf(b)) begin
         calcRes = {sBEff, b[30:0]};
      end else if (normZero || (normExp <= 10'sd0)) begin
         calcRes = '0;
      end else if (normExp >= 10'sd255) begin
         calcRes = {sBig, FP_PINF[30:0]};
      end else begin
         calcRes = {sBig, normExp[7:0], normMag[30:8]};
      end
   end

   // Three-way compare: zeros of either sign are equal, negative magnitudes order reversed.
   logic [30:0] magA, magB;
   logic        sgnA, sgnB;
   fpCmp_t      cmpRes;
   assign magA = (eA == '0) ? 31'd0 : a[30:0];
   assign magB = (eB == '0) ? 31'd0 : b[30:0];
   assign sgnA = (magA != '0) && a[31];
   assign sgnB = (magB != '0) && b[31];
   always_comb begin
      cmpRes = CMP_EQ;
      if (isNan(a) || isNan(b))      cmpRes = CMP_UNORD;
      else if (sgnA != sgnB)         cmpRes = sgnA ? CMP_LT : CMP_GT;
      else if (magA == magB)         cmpRes = CMP_EQ;
      else if ((magA > magB) ^ sgnA) cmpRes = CMP_GT;
      else                           cmpRes = CMP_LT;
   end

   // Output registers: reset wins over enable; outputs hold between operations.
   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
         cmp    <= CMP_EQ;
         valid  <= 1'b0;
         debug  <= '0;
      end else begin
         valid <= enable;
         if (enable) begin
            if (opSel == OP_CMP) begin
               cmp <= cmpRes;
            end else begin
               result <= calcRes;
               debug  <= {4'b0000, normMag[31:4]};
            end
         end
      end
   end

endmodule

// File: tb/tb_float_arith_unit.sv
// Scoreboard bench for float_arith_unit: expectations queued at issue, checked on valid.
module tb_float_arith_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic [31:0] result;
   logic [1:0]  cmp;
   logic        valid;
   logic [31:0] debug;

   float_arith_unit dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .op     (op),
      .a      (a),
      .b      (b),
      .result (result),
      .cmp    (cmp),
      .valid  (valid),
      .debug  (debug)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic [1:0]  cmp;
      logic [31:0] dbg;
      bit          dbgCare;
   } exp_t;

   exp_t        q[$];
   int          nChk = 0;
   int          nFail = 0;
   int          nIssued = 0;
   int          nPulse = 0;
   logic [31:0] curRes = '0;
   logic [1:0]  curCmp = '0;
   logic [31:0] curDbg = '0;
   bit          dbgKnown = 1'b1;

   localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, FINT = 2'd2, CMP = 2'd3;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      nChk++;
      if (got !== expv) begin
         nFail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
      end
   endtask

   // Drive one op at the falling edge and queue what the next rising edge must produce.
   task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ev,
                        input logic [31:0] ed, input bit dc);
      exp_t e;
      @(negedge clk);
      enable = 1'b1; op = o; a = x; b = y;
      if (o == CMP) begin
         curCmp = ev[1:0];
      end else begin
         curRes   = ev;
         curDbg   = ed;
         dbgKnown = dc;
      end
      e.tag = tag; e.res = curRes; e.cmp = curCmp; e.dbg = curDbg; e.dbgCare = dbgKnown;
      q.push_back(e);
      nIssued++;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      enable = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard side: every valid pulse must match the oldest queued expectation.
   always @(posedge clk) begin
      #1;
      if (valid) begin
         nPulse++;
         if (q.size() == 0) begin
            chk("spurious valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, " result"}, result, e.res);
            chk({e.tag, " cmp"}, {30'd0, cmp}, {30'd0, e.cmp});
            if (e.dbgCare) chk({e.tag, " debug"}, debug, e.dbg);
         end
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset valid", {31'd0, valid}, 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset cmp", {30'd0, cmp}, 32'd0);
      chk("reset debug", debug, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      issue("add 1+2", ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0C000000, 1); idle(2);
      issue("add 1.5+2.5", ADD, 32'h3FC00000, 32'h40200000, 32'h40800000, 32'h08000000, 1); idle(2);
      issue("sub 1.5-2.5", SUB, 32'h3FC00000, 32'h40200000, 32'hBF800000, 32'h08000000, 1); idle(2);
      issue("sub 1-1", SUB, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h0, 1); idle(2);
      issue("add -0+-0", ADD, 32'h80000000, 32'h80000000, 32'h00000000, 32'h0, 1); idle(2);
      issue("add inf-inf", ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h0, 0); idle(2);
      issue("add nan", ADD, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'h0, 0); idle(2);
      issue("add inf pass", ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h0, 0); idle(2);
      issue("sub 1-inf", SUB, 32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h0, 0); idle(2);
      issue("add overflow", ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h0FFFFFF0, 1); idle(2);
      issue("add denorm", ADD, 32'h00000001, 32'h3F800000, 32'h3F800000, 32'h08000000, 1); idle(2);

      issue("int 7", FINT, 32'd7, 32'hDEADBEEF, 32'h40E00000, 32'h0E000000, 1); idle(2);
      issue("int -1", FINT, 32'hFFFFFFFF, 32'h0, 32'hBF800000, 32'h08000000, 1); idle(2);
      issue("int 0", FINT, 32'h0, 32'h12345678, 32'h00000000, 32'h0, 1); idle(2);
      issue("int min", FINT, 32'h80000000, 32'h0, 32'hCF000000, 32'h08000000, 1); idle(2);
      issue("int 2^24+1", FINT, 32'd16777217, 32'h0, 32'h4B800000, 32'h08000008, 1); idle(2);

      issue("cmp 1,2", CMP, 32'h3F800000, 32'h40000000, 32'd2, 32'h0, 0); idle(2);
      issue("cmp 2,1", CMP, 32'h40000000, 32'h3F800000, 32'd1, 32'h0, 0); idle(2);
      issue("cmp +0,-0", CMP, 32'h00000000, 32'h80000000, 32'd0, 32'h0, 0); idle(2);
      issue("cmp nan", CMP, 32'h7FC00000, 32'h3F800000, 32'd3, 32'h0, 0); idle(2);
      issue("cmp -inf,1", CMP, 32'hFF800000, 32'h3F800000, 32'd2, 32'h0, 0); idle(2);
      issue("cmp -2,-1", CMP, 32'hC0000000, 32'hBF800000, 32'd2, 32'h0, 0); idle(2);

      // Back-to-back: ADD then CMP on consecutive edges.
      issue("b2b add", ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0C000000, 1);
      issue("b2b cmp", CMP, 32'h40000000, 32'h3F800000, 32'd1, 32'h0, 0);
      idle(3);

      // Reset asserted together with enable: nothing produced, outputs cleared.
      @(negedge clk);
      reset = 1'b1; enable = 1'b1; op = ADD; a = 32'h3F800000; b = 32'h40000000;
      @(posedge clk);
      #1;
      chk("rst+en valid", {31'd0, valid}, 32'd0);
      chk("rst+en result", result, 32'd0);
      chk("rst+en cmp", {30'd0, cmp}, 32'd0);
      chk("rst+en debug", debug, 32'd0);
      @(negedge clk);
      reset = 1'b0; enable = 1'b0;
      curRes = '0; curCmp = '0; curDbg = '0; dbgKnown = 1'b1;

      issue("post-rst add", ADD, 32'h3FC00000, 32'h40200000, 32'h40800000, 32'h08000000, 1); idle(1);
      issue("post-rst cmp", CMP, 32'h3F800000, 32'h40000000, 32'd2, 32'h0, 0); idle(1);

      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #2;
      chk("queue drained", q.size(), 32'd0);
      chk("pulse count", nPulse, nIssued);

      $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
      $finish;
   end

endmodule
